// File: rtl/pattern_scan_arbiter.sv
// Round-robin sharing of one overlapping Mealy serial pattern detector; frame scanned MSB-first, done FRAME_W+1 cycles after grant.
// SCAN_FIRST_MATCH_EN: when defined, a scan stops at its first match and reports a count of 1.
module pattern_scan_arbiter #(
    parameter int               NUM_REQ = 4,
    parameter int               FRAME_W = 16,
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10001,
    parameter int               CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*FRAME_W-1:0]   frame_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         ser_bit,
    output logic                         ser_valid,
    output logic                         done,
    output logic [$clog2(NUM_REQ)-1:0]   done_id,
    output logic [CNT_W-1:0]             match_count,
    output logic                         match_any
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(FRAME_W);
    localparam int HW  = PAT_W - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [FRAME_W-1:0] sreg;
    logic [BCW-1:0]     bitcnt;
    logic [HW-1:0]      hist;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [PAT_W-1:0]   pat_win;
    logic [FRAME_W-1:0] frames [NUM_REQ];
    logic [IDW-1:0]     win_idx, cand;
    logic               win_vld, hit, last, scan_end;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            frames[i] = frame_in[i*FRAME_W +: FRAME_W];
        end
    end

    // Walk downward so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign ser_valid = (state == SHIFT);
    assign ser_bit   = ser_valid & sreg[FRAME_W-1];
    assign busy      = (state != IDLE);
    assign done      = (state == REPORT);
    assign match_any = |match_count;

    assign pat_win   = {hist, ser_bit};
    assign hit       = ser_valid && (pat_win == PATTERN) && (bitcnt >= BCW'(PAT_W - 1));
    assign last      = (bitcnt == BCW'(FRAME_W - 1));
    assign count_nxt = (hit && !(&count)) ? count + CNT_W'(1) : count;

`ifdef SCAN_FIRST_MATCH_EN
    assign scan_end = last | hit;
`else
    assign scan_end = last;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = SHIFT;
            SHIFT:   if (scan_end) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            rr_ptr      <= '0;
            done_id     <= '0;
            sreg        <= '0;
            bitcnt      <= '0;
            hist        <= '0;
            count       <= '0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant   <= NUM_REQ'(1) << win_idx;
                        done_id <= win_idx;
                        sreg    <= frames[win_idx];
                        bitcnt  <= '0;
                        hist    <= '0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    sreg   <= sreg << 1;
                    hist   <= pat_win[HW-1:0];
                    bitcnt <= bitcnt + BCW'(1);
                    count  <= count_nxt;
                    // Final count is published on the edge that enters REPORT.
                    if (scan_end) begin
                        match_count <= count_nxt;
                    end
                end
                REPORT: begin
                    grant  <= '0;
                    rr_ptr <= (done_id == IDW'(NUM_REQ - 1)) ? '0 : done_id + IDW'(1);
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Randomized and directed bench for pattern_scan_arbiter against a window-counting reference model.
module tb_pattern_scan_arbiter;
    localparam int NUM_REQ = 4;
    localparam int FRAME_W = 16;
    localparam int PAT_W   = 5;
    localparam logic [PAT_W-1:0] PAT = 5'b10001;

    logic                             clk;
    logic                             rst;
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ-1:0][FRAME_W-1:0]  frames;
    logic [NUM_REQ-1:0]               grant;
    logic                             busy, ser_bit, ser_valid, done, match_any;
    logic [1:0]                       done_id;
    logic [4:0]                       match_count;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    pattern_scan_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame_in   (frames),
        .grant      (grant),
        .busy       (busy),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .done       (done),
        .done_id    (done_id),
        .match_count(match_count),
        .match_any  (match_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slide a PAT_W window over the frame and count every position equal to the pattern.
    function automatic void ref_scan(input logic [FRAME_W-1:0] f, output int cnt, output int ncyc);
        logic [PAT_W-1:0] win;
        cnt  = 0;
        ncyc = FRAME_W;
        for (int s = 0; s + PAT_W <= FRAME_W; s++) begin
            win = f[FRAME_W-1-s -: PAT_W];
            if (win == PAT && ncyc == FRAME_W) begin
                cnt++;
`ifdef SCAN_FIRST_MATCH_EN
                ncyc = s + PAT_W;
`endif
            end
        end
    endfunction

    function automatic int ref_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        int idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic scan_check(input string tag, input int id, input logic [FRAME_W-1:0] f);
        int cnt, ncyc;
        logic [NUM_REQ-1:0] oh;
        ref_scan(f, cnt, ncyc);
        oh = 4'd1 << id;
        for (int i = 0; i < ncyc; i++) begin
            chk({tag, "_shift"}, {grant, busy, ser_valid, ser_bit, done},
                {oh, 1'b1, 1'b1, f[FRAME_W-1-i], 1'b0});
            tick();
        end
        chk({tag, "_report"}, {grant, busy, ser_valid, done, done_id}, {oh, 1'b1, 1'b0, 1'b1, 2'(id)});
        chk({tag, "_count"}, match_count, 32'(cnt));
        chk({tag, "_any"}, match_any, 32'(cnt != 0));
        tick();
        chk({tag, "_idle"}, {grant, busy, done, match_count}, {4'b0, 1'b0, 1'b0, 5'(cnt)});
        rr_ptr = (id + 1) % NUM_REQ;
    endtask

    // Present r in IDLE, let the next edge sample it, then scramble inputs the DUT must ignore.
    task automatic issue(input string tag, input logic [NUM_REQ-1:0] r, input bit hold);
        int w;
        logic [FRAME_W-1:0] f;
        req = r;
        w = ref_pick(r, rr_ptr);
        f = (w >= 0) ? frames[w] : '0;
        tick();
        if (!hold) req = '0;
        for (int i = 0; i < NUM_REQ; i++) frames[i] = 16'($urandom);
        if (w < 0) begin
            chk({tag, "_noreq"}, {grant, busy, done}, 0);
        end else begin
            scan_check(tag, w, f);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_ptr = 0;
    endtask

    initial begin
        int pulses;
        rst    = 1'b1;
        req    = '0;
        frames = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_outputs", {grant, busy, ser_bit, ser_valid, done, done_id, match_count, match_any}, 0);

        // Three overlapping occurrences in 8888; a one-cycle request must still complete once.
        frames[0] = 16'h8888;
        issue("f8888", 4'b0001, 1'b0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("oneshot_no_redone", pulses, 0);

        frames[1] = 16'h8421;
        issue("f8421", 4'b0010, 1'b0);
        frames[1] = 16'hFFFF;
        issue("fFFFF", 4'b0010, 1'b0);
        frames[2] = 16'h0000;
        issue("f0000", 4'b0100, 1'b0);

        // Held requests rotate 0,1,2,3,0 with back-to-back 18-cycle spacing.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            issue("rr_hold", 4'b1111, 1'b1);
        end
        req = '0;
        tick();

        // Reset in the 8th SHIFT cycle aborts silently and restarts arbitration at channel 0.
        frames[2] = 16'h8888;
        req = 4'b0100;
        tick();
        req = '0;
        for (int i = 0; i < 7; i++) tick();
        chk("midscan_busy", {busy, ser_valid}, 2'b11);
        do_reset();
        chk("midscan_reset", {grant, busy, ser_valid, done, match_count, match_any}, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("midscan_no_done", pulses, 0);
        for (int i = 0; i < NUM_REQ; i++) frames[i] = 16'($urandom);
        issue("after_reset", 4'b1111, 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NUM_REQ; i++) frames[i] = 16'($urandom & $urandom);
            if (n % 5 == 0) frames[n % NUM_REQ] = 16'h8888;
            issue("random", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
- Shares one bit-serial, overlapping Mealy pattern detector (default pattern 10001) between NUM_REQ requesters.
- A round-robin arbiter grants one requester at a time and captures its parallel frame.
- The frame is shifted MSB-first through the detector, one bit per clock, and every pattern occurrence is counted.
- The count is reported with a one-cycle done strobe; the block sits between parallel capture logic and the serial detectors.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- FRAME_W, 16, bits per frame (>= PAT_W)
- PAT_W, 5, pattern length (2..8)
- PATTERN, 5'b10001, pattern, MSB = first bit in time
- CNT_W, $clog2(FRAME_W+1), match counter width (derived, do not override)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  request per channel; level-sensitive, sampled only in IDLE
- frame_in  in  NUM_REQ*FRAME_W  channel i frame at bits [i*FRAME_W +: FRAME_W]
- grant  out  NUM_REQ  one-hot owner of the detector; 0 when idle
- busy  out  1  high in SHIFT and REPORT
- ser_bit  out  1  bit currently presented to the detector
- ser_valid  out  1  high for each SHIFT cycle
- done  out  1  one-cycle strobe in REPORT
- done_id  out  $clog2(NUM_REQ)  index of the reported channel
- match_count  out  CNT_W  matches in the finished frame; holds until the next REPORT
- match_any  out  1  match_count != 0, same timing

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, grant=0, rr_ptr=0, count=0, hist=0, match_count=0, done_id=0. All outputs are 0.
- Reset mid-scan aborts the scan without reporting; done does not fire.
- FSM states: IDLE, SHIFT, REPORT. All outputs are registered or decoded from registered state.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On that edge: grant<=onehot(winner), done_id<=winner, sreg<=winner's frame, bitcnt<=0, hist<=0, count<=0, state<=SHIFT.
- SHIFT (exactly FRAME_W cycles):
  - ser_bit=sreg[MSB], ser_valid=1.
  - Each edge: sreg<<=1; hist<={hist[PAT_W-3:0],ser_bit}; bitcnt++.
  - Mealy match condition: {hist,ser_bit}==PATTERN and bitcnt>=PAT_W-1. On a match, count++ with saturation at 2^CNT_W-1.
  - Matching is overlapping: hist is not cleared on a match.
  - On the edge where bitcnt==FRAME_W-1, go to REPORT.
- REPORT (one cycle):
  - done=1. match_count and match_any already reflect the final count, which is loaded on the entry edge.
  - grant stays held.
  - Next edge: grant<=0, rr_ptr<=(done_id+1) mod NUM_REQ, state<=IDLE.
- Latency:
  - Request sampled at edge E0; SHIFT occupies the FRAME_W cycles after E0; done is high in cycle E0+FRAME_W+1.
  - The minimum issue interval per frame is FRAME_W+2 cycles.
- Edge cases:
  - Changes to req or frame_in after the IDLE sampling edge are ignored until the next IDLE.
  - History is cleared per frame, so no match spans two frames.
  - A requester that stays asserted is re-granted only after every other active requester has had a turn.

Optional Feature:
- Macro: SCAN_FIRST_MATCH_EN.
- Defined: on the first match edge, count<=1 and state<=REPORT immediately; the remaining bits are dropped.
- Defined, no match found: the scan behaves as when undefined and reports 0.
- Undefined: the full FRAME_W-bit scan always runs and all matches are counted.

Test Plan:
- Reset, then req=4'b0001, frame0=16'h8888 -> grant=0001 for 17 cycles; done at E0+17 with match_count=3, match_any=1, done_id=0 (overlapping matches at bit offsets 0, 4, 8).
- req=4'b0010, frame1=16'h8421 (four zeros between the ones) -> match_count=0, match_any=0; frame1=16'hFFFF -> 0.
- After reset, req=4'b1111 held continuously -> done_id sequence 0,1,2,3,0; each done is 18 cycles apart; grant is always one-hot.
- Assert rst during the 8th SHIFT cycle of frame 16'h8888 -> next cycle grant=0, busy=0, match_count=0; no done; the next grant goes to channel 0.
- req=4'b0001 asserted for one cycle only, then dropped -> the scan still completes and done fires once.
- With SCAN_FIRST_MATCH_EN defined and frame 16'h8888 -> done at E0+6, match_count=1; with frame 16'h0000 -> done at E0+17, count=0.
